mem_responder: RTL

Memory-side responder for the core's data-memory valid/ready handshake. It serves NUM_CHANNELS independent consumers (LSUs or cores), each with a read and a write channel. Requests are arbitrated round-robin onto a single-port word RAM, one access per cycle. Each response is returned after a fixed LATENCY. It sits between the cores' data-memory ports and the backing store, and doubles as the bench memory model.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_rr_arbiter.sv | 49 ++++
 rtl/mem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants for the data-memory responder.
// Channel FSM encoding and the operation kind held per channel.
package mem_responder_pkg;

    typedef logic [1:0] ch_state_t;

    localparam ch_state_t ST_IDLE     = 2'd0;
    localparam ch_state_t ST_INFLIGHT = 2'd1;
    localparam ch_state_t ST_RELEASE  = 2'd2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_responder_rr_arbiter.sv
// Round-robin request/grant arbiter with a registered start pointer.
// One-hot grant; the pointer moves past the winner on every grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid
);
    import mem_responder_pkg::*;

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW:0]   idx;

    // Scan N slots starting at ptr; first requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        gidx        = '0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N))
                idx = idx - (PW+1)'(N);
            if (!grant_valid && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                grant_valid        = 1'b1;
                gidx               = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            if (gidx == PW'(N - 1))
                ptr <= '0;
            else
                ptr <= gidx + PW'(1);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-channel read/write responder on a single-port word RAM.
// One grant per cycle, fixed latency, ready held until valid drops.
module mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CHANNELS-1:0]        mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]        mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]        mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]        mem_write_ready,
    input  logic                           init_write_enable,
    input  logic [ADDR_BITS-1:0]           init_address,
    input  logic [DATA_BITS-1:0]           init_data
);
    import mem_responder_pkg::*;

    localparam int NC = NUM_CHANNELS;
    localparam int CW = $clog2(LATENCY + 1);

    ch_state_t            state  [NC];
    logic                 op     [NC];
    logic [CW-1:0]        cnt    [NC];
    logic [DATA_BITS-1:0] sample [NC];

    logic [NC-1:0]           req;
    logic [NC-1:0]           grant;
    logic                    grant_valid;
    logic [NC-1:0]           rd_rdy;
    logic [NC-1:0]           wr_rdy;
    logic [NC*DATA_BITS-1:0] rd_data;

    logic [DATA_BITS-1:0] ram [2**ADDR_BITS];

    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 all_idle;

    always_comb begin
        for (int i = 0; i < NC; i++)
            req[i] = (state[i] == ST_IDLE) &&
                     (mem_read_valid[i] || mem_write_valid[i]);
    end

    rr_arbiter #(
        .N (NC)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // A granted channel with both valids high is serving its write.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        all_idle = !grant_valid;
        for (int i = 0; i < NC; i++) begin
            if (state[i] != ST_IDLE)
                all_idle = 1'b0;
            if (grant[i] && mem_write_valid[i]) begin
                wr_en   = 1'b1;
                wr_addr = mem_write_address[i*ADDR_BITS +: ADDR_BITS];
                wr_data = mem_write_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr] <= wr_data;
        else if (init_write_enable && all_idle)
            ram[init_address] <= init_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_rdy  <= '0;
            wr_rdy  <= '0;
            rd_data <= '0;
            for (int i = 0; i < NC; i++) begin
                state[i]  <= ST_IDLE;
                op[i]     <= OP_READ;
                cnt[i]    <= '0;
                sample[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        if (grant[i]) begin
                            state[i] <= ST_INFLIGHT;
                            cnt[i]   <= CW'(LATENCY);
                            if (mem_write_valid[i]) begin
                                op[i] <= OP_WRITE;
                            end else begin
                                op[i]     <= OP_READ;
                                sample[i] <= ram[mem_read_address[i*ADDR_BITS +: ADDR_BITS]];
                            end
                        end
                    end
                    ST_INFLIGHT: begin
                        if (cnt[i] == CW'(1)) begin
                            state[i] <= ST_RELEASE;
                            cnt[i]   <= '0;
                            if (op[i] == OP_WRITE) begin
                                wr_rdy[i] <= 1'b1;
                            end else begin
                                rd_rdy[i] <= 1'b1;
                                rd_data[i*DATA_BITS +: DATA_BITS] <= sample[i];
                            end
                        end else begin
                            cnt[i] <= cnt[i] - CW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if ((op[i] == OP_WRITE) ? !mem_write_valid[i]
                                                : !mem_read_valid[i]) begin
                            rd_rdy[i] <= 1'b0;
                            wr_rdy[i] <= 1'b0;
                            state[i]  <= ST_IDLE;
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_read_ready  = rd_rdy;
    assign mem_write_ready = wr_rdy;
    assign mem_read_data   = rd_data;

endmodule
